// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the BCD converter
package bcd_pkg;

  // Converter control states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of one packed BCD digit
  localparam int DIGIT_W = 4;

  // Largest value representable in the given number of decimal digits
  function automatic int bcd_max(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 correction for one BCD digit before a shift
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // Digits of 5 or more would exceed 9 after doubling, so pre-bias by 3
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= DIGIT_W'(5)) begin
      o_digit = i_digit + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIN_W-1:0]           in_bin,
  output logic                       out_valid,
  output logic [DIGIT_W*DIGITS-1:0]  out_bcd,
  output logic                       out_ovf
);

  // One spare digit keeps intermediate carries during the shift
  localparam int BCD_W = DIGIT_W * (DIGITS + 1);
  localparam int OUT_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CMP_W = BIN_W + 4;
  localparam logic [CMP_W-1:0] MAX_VAL   = CMP_W'(bcd_max(DIGITS));
  localparam logic [OUT_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t                   r_state;
  state_t                   w_state_next;
  logic [BIN_W-1:0]         r_bin_sr;
  logic [BCD_W-1:0]         r_bcd_sr;
  logic [CNT_W-1:0]         r_bit_cnt;
  logic                     r_ovf;
  logic                     r_out_valid;
  logic [OUT_W-1:0]         r_out_bcd;
  logic                     r_out_ovf;
  logic [BCD_W-1:0]         w_adj;
  logic [BCD_W+BIN_W-1:0]   w_shift;
  logic                     w_accept;
  logic                     w_done;

  // Per-digit add-3 correction on the current BCD accumulator
  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_bcd_sr[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_shift = {w_adj, r_bin_sr} << 1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake; ready never looks at in_valid
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        w_accept = in_valid;
        if (in_valid) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_done = (r_bit_cnt == CNT_W'(1));
        if (w_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_sr    <= '0;
      r_bcd_sr    <= '0;
      r_bit_cnt   <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_bin_sr  <= in_bin;
        r_bcd_sr  <= '0;
        r_bit_cnt <= CNT_W'(BIN_W);
        r_ovf     <= ({4'b0, in_bin} > MAX_VAL);
      end else if (r_state == SHIFT) begin
        r_bcd_sr  <= w_shift[BCD_W+BIN_W-1:BIN_W];
        r_bin_sr  <= w_shift[BIN_W-1:0];
        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
        if (w_done) begin
          r_out_bcd   <= r_ovf ? ALL_NINES : w_shift[BIN_W+OUT_W-1:BIN_W];
          r_out_ovf   <= r_ovf;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_bin = '0;
  logic        out_valid;
  logic [11:0] out_bcd;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   pulse_cyc[$];

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_bcd   (out_bcd),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Decimal reference: digits by division, saturating above 999
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] res;
    int r;
    res = '0;
    if (v > 999) return 12'h999;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      res[d*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record accepted transfers into the scoreboard
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      e.bcd     = ref_bcd(int'(in_bin));
      e.ovf     = (int'(in_bin) > 999);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  end

  // Monitor: compare each presented result against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      pulse_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: bcd=%0h at cycle %0d", out_bcd, cyc);
      end else begin
        e = sb.pop_front();
        chk("out_bcd", int'(out_bcd), int'(e.bcd));
        chk("out_ovf", int'(out_ovf), int'(e.ovf));
        chk("latency", cyc - e.acc_cyc, BIN_W);
      end
    end
  end

  // Present a value and wait until it is accepted; called just after a negedge
  task automatic send(input logic [9:0] v, input bit hold, input bit scramble);
    int n;
    in_valid = 1'b1;
    in_bin   = v;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    if (scramble) in_bin = 10'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int lows;
    int v;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bcd", int'(out_bcd), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);

    send(10'd0, 0, 0);
    drain();

    send(10'd255, 0, 0);
    lows = 0;
    while (!in_ready && lows < 30) begin
      @(negedge clk);
      if (!in_ready) lows++;
    end
    chk("busy_cycles", lows, 10);
    drain();

    send(10'd999, 0, 0);
    drain();
    send(10'd1023, 0, 0);
    drain();
    send(10'd1000, 0, 0);
    drain();

    // Continuous in_valid: back-to-back conversions
    pulse_cyc.delete();
    send(10'd1, 1, 0);
    send(10'd10, 1, 0);
    send(10'd100, 0, 0);
    drain();
    chk("b2b_pulses", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      chk("b2b_gap0", pulse_cyc[1] - pulse_cyc[0], 11);
      chk("b2b_gap1", pulse_cyc[2] - pulse_cyc[1], 11);
    end

    // Reset mid-conversion
    send(10'd512, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_bcd", int'(out_bcd), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    pulse_cyc.delete();
    repeat (15) @(negedge clk);
    chk("midrst_no_pulse", pulse_cyc.size(), 0);
    send(10'd42, 0, 0);
    drain();

    // Random values, input scrambled during conversion, random gaps and holds
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 1023));
      send(10'(v), ($urandom_range(0, 1) == 1), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
